uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
UART transmitter that drains the transmit FIFO and serialises each byte onto the TX pin as 8N1 (or 8N2) at a fixed baud rate.
- Sits directly downstream of the transmit FIFO.
- The FIFO's output word is valid whenever EMPTY is low (first-word fall-through), and a POP advances it.
- This block pops one word per frame and drives the IceStick TX pad.

Parameters:
DATA_WIDTH, 8, bits per character; only FIFO_DATA[DATA_WIDTH-1:0] is used.
CLKS_PER_BIT, 104, CLK cycles per bit period (12 MHz / 115200); legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RESET  input  1  asynchronous, active-high reset.
ENABLE  input  1  when 1, new frames may start; a frame in progress always completes.
FIFO_DATA  input  DATA_WIDTH  head-of-FIFO word; valid when FIFO_EMPTY=0.
FIFO_EMPTY  input  1  FIFO has no data.
FIFO_POP  output  1  one-cycle pop strobe to the FIFO.
TX  output  1  serial line; idles high.
BUSY  output  1  high while a frame is in progress (state != IDLE).
DONE  output  1  one-cycle pulse when a frame's last stop bit ends.

Behaviour:
- Reset state: IDLE.
- Reset output values: TX=1, BUSY=0, DONE=0, FIFO_POP=0.
- Reset is asynchronous: TX goes to 1 immediately on RESET assertion, with no clock edge required.
- FIFO_POP is combinational: ENABLE && !FIFO_EMPTY && state==IDLE && !RESET.
  - Never high for two consecutive cycles.
  - Never high outside IDLE.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - TX=1.
  - If FIFO_POP=1, then at that edge: latch FIFO_DATA into the shift register, clear the baud counter and bit index, and go to START.
- START:
  - TX=0 for exactly CLKS_PER_BIT cycles, starting the cycle after the pop.
  - Then go to DATA.
- DATA:
  - DATA_WIDTH bits, LSB first, each held exactly CLKS_PER_BIT cycles.
  - Shift right at each bit boundary.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP:
  - TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle, DONE is registered high for the next cycle, and state returns to IDLE.
- TX is a registered output: no glitches, and bit boundaries are exact to the cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index:
  - Width $clog2(DATA_WIDTH)+1.
  - Wraps to 0 when a new frame starts.
- Back-to-back: with the FIFO non-empty, the next pop occurs in the single IDLE cycle after STOP. Frame-to-frame spacing is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT + 1 cycles.
- ENABLE:
  - Deasserted mid-frame: the current frame finishes normally, and no further pop occurs until ENABLE returns to 1.
  - Deasserted in IDLE: FIFO_POP=0 and TX=1.
- FIFO_EMPTY rising mid-frame: ignored, because the data is already latched.
- FIFO_DATA changes after the pop: ignored.
- RESET mid-frame:
  - The frame is aborted. The partial character is lost; no retry.
  - State goes to IDLE, TX=1, and counters clear.
  - The first pop after RESET deasserts occurs on the first edge with ENABLE && !FIFO_EMPTY.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8.
1. Reset check: assert RESET with FIFO_EMPTY=0 and ENABLE=1 -> FIFO_POP=0, TX=1, BUSY=0, DONE=0 throughout reset.
2. Single byte: FIFO holds 0xA5, ENABLE=1.
   - FIFO_POP is high for exactly 1 cycle.
   - TX then carries the 10-bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
   - DONE pulses once, then TX stays 1.
3. Back-to-back: FIFO holds 0x00 then 0xFF -> the second FIFO_POP occurs exactly 41 cycles after the first; TX sequences are correct for both frames, with no extra idle cycles.
4. ENABLE drop: deassert ENABLE during data bit 3 of 0x3C with a second word queued -> the 0x3C frame completes intact; no further FIFO_POP while ENABLE=0; the second frame starts one cycle after ENABLE returns to 1.
5. Async reset: pulse RESET between clock edges during data bit 5 -> TX=1 and BUSY=0 before the next edge; after release the next queued byte transmits correctly.
6. STOP_BITS=2: send 0x55 twice -> stop period is 8 cycles; pop spacing is 45 cycles.

Source files
------------

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a first-word-fall-through FIFO, one 8N1/8N2 frame per popped word.
// TX is registered; the pop is combinational so a word is taken the same edge IDLE sees data.
module uart_tx_drain #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_POP,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  pop;
  logic                  bit_end;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = ENABLE && !FIFO_EMPTY && (state_q == S_IDLE) && !RESET;
    bit_end = (cnt_q == CNT_LAST);

    // tx_d always carries the level for the bit period that begins at this edge
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = FIFO_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign FIFO_POP = pop;
  assign TX       = tx_q;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: lane 0 uses one stop bit, lane 1 two; a FIFO model feeds each lane and
// a frame monitor compares the sampled TX waveform against bytes queued in a scoreboard.
module tb_uart_tx_drain;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = 2'b00;
  logic [7:0] fdata [2] = '{8'h00, 8'h00};
  logic [1:0] fempty = 2'b11;
  logic [1:0] pop, tx, busy, done;

  logic [7:0]  fq [2][$];
  logic [7:0]  sb [2][$];
  int unsigned pop_log [2][$];

  logic        in_f   [2] = '{1'b0, 1'b0};
  int unsigned fc     [2] = '{0, 0};
  logic [47:0] obs    [2] = '{48'h0, 48'h0};
  logic [7:0]  expb   [2] = '{8'h00, 8'h00};
  logic        bad    [2] = '{1'b0, 1'b0};
  int unsigned frames [2] = '{0, 0};
  logic [1:0]  pop_prev = 2'b00;
  logic [1:0]  pop_seen = 2'b00;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .CLK(clk), .RESET(rst), .ENABLE(en[0]), .FIFO_DATA(fdata[0]), .FIFO_EMPTY(fempty[0]),
    .FIFO_POP(pop[0]), .TX(tx[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RESET(rst), .ENABLE(en[1]), .FIFO_DATA(fdata[1]), .FIFO_EMPTY(fempty[1]),
    .FIFO_POP(pop[1]), .TX(tx[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    fq[g].push_back(b);
    sb[g].push_back(b);
  endtask

  function automatic logic [47:0] frame_bits(input logic [7:0] b, input int unsigned sbits);
    logic [47:0] w;
    int unsigned fl;
    int unsigned k;
    logic        bt;
    w  = '0;
    fl = (9 + sbits) * CPB;
    for (int unsigned c = 0; c < fl; c++) begin
      k = c / CPB;
      if (k == 0)      bt = 1'b0;
      else if (k <= 8) bt = b[k-1];
      else             bt = 1'b1;
      w = {w[46:0], bt};
    end
    return w;
  endfunction

  task automatic wait_pop(input int g, input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (pop_log[g].size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq("pop_seen", 64'(pop_log[g].size()), 64'(n));
  endtask

  task automatic wait_frames(input int g, input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (frames[g] < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq("frames_reached", 64'(frames[g]), 64'(n));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pop on the edge the DUT popped, then present the new head well after the edge
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (pop_seen[g] && fq[g].size() > 0) fq[g].delete(0);
    #2;
    for (int g = 0; g < 2; g++) begin
      fempty[g] = (fq[g].size() == 0);
      fdata[g]  = (fq[g].size() > 0) ? fq[g][0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int unsigned fl;
      fl = (10 + g) * CPB;
      pop_seen[g] = pop[g];
      if (pop[g]) pop_log[g].push_back(cyc);
      if (rst) begin
        check_eq("reset_outs", 64'({pop[g], tx[g], busy[g], done[g]}), 64'(4'b0100));
        in_f[g] = 1'b0;
      end else begin
        check_eq("pop_legal", 64'({pop[g] & pop_prev[g], pop[g] & busy[g]}), 64'(2'b00));
        if (!in_f[g]) begin
          if (tx[g] == 1'b0) begin
            in_f[g] = 1'b1;
            fc[g]   = 0;
            obs[g]  = '0;
            bad[g]  = 1'b0;
            check_eq("frame_expected", 64'(sb[g].size() != 0), 64'(1));
            expb[g] = (sb[g].size() > 0) ? sb[g].pop_front() : 8'h00;
          end else begin
            check_eq("idle_outs", 64'({busy[g], done[g]}), 64'(2'b00));
          end
        end
        if (in_f[g]) begin
          if (fc[g] < fl) begin
            obs[g] = {obs[g][46:0], tx[g]};
            if (done[g] || !busy[g]) bad[g] = 1'b1;
            fc[g]++;
          end else begin
            check_eq("frame_tx", 64'(obs[g]), 64'(frame_bits(expb[g], g + 1)));
            check_eq("frame_end", 64'({bad[g], busy[g], done[g], tx[g]}), 64'(4'b0011));
            in_f[g] = 1'b0;
            frames[g]++;
          end
        end
      end
      pop_prev[g] = pop[g];
    end
  end

  initial begin
    int unsigned n0;
    int unsigned tc;

    // reset held with data available and enable high
    en = 2'b01;
    push(0, 8'hA5);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    tc = cyc;

    // single byte
    wait_pop(0, 1, 20);
    check_eq("first_pop_cycle", 64'(pop_log[0][0]), 64'(tc));
    wait_frames(0, 1, 100);
    repeat (10) @(posedge clk);
    #1;
    check_eq("single_pop_count", 64'(pop_log[0].size()), 64'(1));
    check_eq("idle_tx_high", 64'(tx[0]), 64'(1));

    // back-to-back
    @(posedge clk);
    #1;
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_frames(0, 3, 200);
    check_eq("b2b_spacing", 64'(pop_log[0][2] - pop_log[0][1]), 64'(41));

    // enable dropped during data bit 3
    @(posedge clk);
    #1;
    push(0, 8'h3C);
    push(0, 8'h81);
    n0 = pop_log[0].size();
    wait_pop(0, n0 + 1, 20);
    repeat (17) @(posedge clk);
    #1 en[0] = 1'b0;
    wait_frames(0, 4, 100);
    repeat (20) @(posedge clk);
    #1;
    check_eq("no_pop_disabled", 64'(pop_log[0].size()), 64'(n0 + 1));
    check_eq("disabled_tx", 64'({tx[0], busy[0], pop[0]}), 64'(3'b100));
    @(posedge clk);
    #1 en[0] = 1'b1;
    tc = cyc;
    wait_pop(0, n0 + 2, 20);
    check_eq("enable_restart", 64'(pop_log[0][n0 + 1]), 64'(tc));
    wait_frames(0, 5, 100);

    // asynchronous reset during data bit 5
    @(posedge clk);
    #1;
    push(0, 8'h5A);
    push(0, 8'hC3);
    n0 = pop_log[0].size();
    wait_pop(0, n0 + 1, 20);
    repeat (25) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_reset", 64'({tx[0], busy[0], pop[0]}), 64'(3'b100));
    @(posedge clk);
    #1 rst = 1'b0;
    tc = cyc;
    wait_pop(0, n0 + 2, 20);
    check_eq("post_reset_pop", 64'(pop_log[0][n0 + 1]), 64'(tc));
    wait_frames(0, 6, 100);

    // two stop bits
    @(posedge clk);
    #1;
    en[1] = 1'b1;
    push(1, 8'h55);
    push(1, 8'h55);
    wait_frames(1, 2, 200);
    check_eq("sb2_pop_count", 64'(pop_log[1].size()), 64'(2));
    check_eq("sb2_spacing", 64'(pop_log[1][1] - pop_log[1][0]), 64'(45));

    repeat (5) @(posedge clk);
    #1;
    check_eq("sb_drained", 64'(sb[0].size() + sb[1].size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
